// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Asynchronous serial frame receiver. It recovers LSB-first
//               frames from a 1-bit line that idles high. Each frame has one
//               start bit (0), DATA_BITS data bits, an optional even parity
//               bit and one stop bit (1). Each good word is presented on a
//               parallel bus with a one-cycle valid strobe.
//
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high reset
//               d          - serial line, asynchronous to clk, idles high
//               data       - last good received word
//               valid      - 1-cycle strobe, data updated this cycle
//               frame_err  - 1-cycle strobe, stop bit sampled low
//               parity_err - 1-cycle strobe, parity mismatch (0 unless enabled)
//               busy       - high whenever the receiver is not idle
//
// Parameters  : DATA_BITS    - data bits per frame (1..16)
//               CLKS_PER_BIT - clk cycles per serial bit (even, >= 2)
//
// Options     : `define RX_PARITY_EN adds an even-parity bit after the data
//               bits and enables parity_err.
//
// Revision    : 1.0 - initial release
// ============================================================================

module serial_frame_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int c_HALF  = CLKS_PER_BIT / 2;
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE       = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF_LAST = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE       = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST      = c_IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_BREAK  = 3'd5;

    // Two-flop synchronizer. Only r_sync2 is used by the FSM.
    logic                 r_sync1;
    logic                 r_sync2;

    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_busy;

    // Value of the shift register after the current line bit is shifted in.
    // The line bit enters at the MSB, so the first bit received ends up at
    // bit 0 once all DATA_BITS bits have been shifted in.
    logic [DATA_BITS-1:0] w_shift_next;

    generate
        if (DATA_BITS == 1) begin : g_shift_single
            assign w_shift_next = r_sync2;
        end else begin : g_shift_multi
            assign w_shift_next = {r_sync2, r_shreg[DATA_BITS-1:1]};
        end
    endgenerate

`ifdef RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_par_bad;

    // Even parity: the received parity bit must equal the XOR of the data.
    assign w_par_bad = r_par_bit ^ (^r_shreg);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1     <= d;
            r_sync2     <= r_sync1;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= c_ST_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                // Re-check the start bit half a bit in. This rejects short
                // glitches and aligns every later sample to mid-bit.
                c_ST_START: begin
                    if (r_cnt == c_CNT_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!r_sync2) begin
                            r_state   <= c_ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_DATA: begin
                    if (r_cnt == c_CNT_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shreg   <= w_shift_next;
                        r_bit_idx <= r_bit_idx + c_IDX_ONE;
                        if (r_bit_idx == c_IDX_LAST) begin
`ifdef RX_PARITY_EN
                            r_state <= c_ST_PARITY;
`else
                            r_state <= c_ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

`ifdef RX_PARITY_EN
                c_ST_PARITY: begin
                    if (r_cnt == c_CNT_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bit <= r_sync2;
                        r_state   <= c_ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
`endif

                // A low stop bit always wins over a parity mismatch.
                c_ST_STOP: begin
                    if (r_cnt == c_CNT_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
`ifdef RX_PARITY_EN
                            if (w_par_bad) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_data  <= r_shreg;
                                r_valid <= 1'b1;
                            end
`else
                            r_data  <= r_shreg;
                            r_valid <= 1'b1;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                // A line held low (break) must not be taken as a new start bit.
                c_ST_BREAK: begin
                    if (r_sync2) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
`ifdef RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Self-checking bench for serial_frame_rx. It runs directed
//               scenarios and then randomized frames, glitches, breaks and
//               gaps. A frame-level reference model predicts each strobe's
//               kind, cycle and data from the frame timing rules.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_serial_frame_rx;

    localparam int DATA_BITS    = 8;
    localparam int CLKS_PER_BIT = 4;
    localparam int HALF         = CLKS_PER_BIT / 2;
`ifdef RX_PARITY_EN
    localparam int PAR_BITS     = 1;
`else
    localparam int PAR_BITS     = 0;
`endif
    // First low edge t0 -> strobe is visible after edge t0 + LAT.
    localparam int LAT = 2 + HALF + (DATA_BITS + 1 + PAR_BITS) * CLKS_PER_BIT;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b001;

    logic                 clk;
    logic                 reset;
    logic                 d;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    serial_frame_rx #(
        .DATA_BITS    (DATA_BITS),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]           kind;
        logic [DATA_BITS-1:0] word;
        int                   at;
    } exp_t;

    exp_t                 expq[$];
    logic [DATA_BITS-1:0] mdl_data = '0;
    int                   n_checks = 0;
    int                   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (expq.size() > 0 && expq[0].at < cyc) begin
                check("strobe_missing", 32'(cyc), 32'(expq[0].at));
                void'(expq.pop_front());
            end
            if (valid || frame_err || parity_err) begin
                check("strobe_onehot", 32'(valid) + 32'(frame_err) + 32'(parity_err), 1);
                if (expq.size() == 0) begin
                    check("strobe_unexpected", {valid, frame_err, parity_err}, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("strobe_kind", {valid, frame_err, parity_err}, e.kind);
                    check("strobe_cycle", 32'(cyc), 32'(e.at));
                    check("busy_at_strobe", busy, (e.kind == K_FERR));
                    if (e.kind == K_VALID) begin
                        check("valid_data", data, e.word);
                        mdl_data = e.word;
                    end
                end
            end
            check("data_hold", data, mdl_data);
        end
    end

    // Hold the line at b for n cycles. Changes are made 1 time unit after a
    // rising edge.
    task automatic line(input logic b, input int n);
        d = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        d     = 1'b1;
        expq.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        mdl_data = '0;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_busy", busy, 0);
    endtask

    // Send one frame. The expected strobe is predicted from the frame rules
    // before the line is driven. A low stop bit is held low for extra cycles,
    // and then the line idles high for a few cycles.
    task automatic send(input logic [DATA_BITS-1:0] w, input bit good_stop,
                        input bit good_par, input int low_hold);
        exp_t e;
        logic pb;
        e.word = w;
        e.at   = cyc + 1 + LAT;
        if (!good_stop)
            e.kind = K_FERR;
        else if (PAR_BITS != 0 && !good_par)
            e.kind = K_PERR;
        else
            e.kind = K_VALID;
        expq.push_back(e);
        line(1'b0, CLKS_PER_BIT);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < DATA_BITS; i++) line(w[i], CLKS_PER_BIT);
        pb = (^w) ^ !good_par;
        if (PAR_BITS != 0) line(pb, CLKS_PER_BIT);
        if (good_stop) begin
            line(1'b1, CLKS_PER_BIT);
        end else begin
            line(1'b0, CLKS_PER_BIT + low_hold);
            line(1'b1, 4);
        end
    endtask

    task automatic glitch();
        line(1'b0, 1);
        line(1'b1, 6);
    endtask

    logic [7:0] w81;

    initial begin
        reset = 1'b1;
        d     = 1'b1;
        #1;
        do_reset(2);
        line(1'b1, 50);
        check("idle_busy", busy, 0);

        // Good frame, then a glitch followed by a good frame.
        send(8'hA5, 1'b1, 1'b1, 0);
        line(1'b1, 3);
        check("idle_after_a5", busy, 0);
        glitch();
        check("idle_after_glitch", busy, 0);
        send(8'h3C, 1'b1, 1'b1, 0);
        line(1'b1, 5);

        // Framing error with a long break, then recovery.
        send(8'h5A, 1'b0, 1'b1, 15);
        send(8'h0F, 1'b1, 1'b1, 0);
        line(1'b1, 5);

        // Back-to-back frames with no gap between them.
        send(8'h00, 1'b1, 1'b1, 0);
        send(8'hFF, 1'b1, 1'b1, 0);
        line(1'b1, 5);

        // Reset during data bit 4 of 0x81 discards the partial frame.
        w81 = 8'h81;
        line(1'b0, CLKS_PER_BIT);
        for (int i = 0; i < 4; i++) line(w81[i], CLKS_PER_BIT);
        line(w81[4], 2);
        do_reset(1);
        line(1'b1, 2 * LAT);
        send(8'h81, 1'b1, 1'b1, 0);
        line(1'b1, 5);
        if (PAR_BITS != 0) begin
            send(8'h81, 1'b1, 1'b0, 0);
            line(1'b1, 5);
        end

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)
                glitch();
            else if (r == 1)
                send(DATA_BITS'($urandom), 1'b0, 1'b1, $urandom_range(0, 20));
            else if (r == 2)
                send(DATA_BITS'($urandom), 1'b1, (PAR_BITS == 0), 0);
            else
                send(DATA_BITS'($urandom), 1'b1, 1'b1, 0);
            line(1'b1, $urandom_range(0, 6));
        end

        line(1'b1, LAT + 10);
        check("pending_strobes", expq.size(), 0);
        check("final_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
